// File: rtl/ifu_fetch_buf_if.sv
// ifu_fetch_buf_if: imem request/response, ID handoff and redirect signals of the fetch unit
interface ifu_fetch_buf_if #(
   parameter int XLEN = 64,
   parameter int INST_LEN = 32,
   parameter int DEPTH = 2
);
   logic is_jump_i;
   logic [XLEN-1:0] pc_jump_i;
   logic imem_req_valid_o;
   logic imem_req_ready_i;
   logic [XLEN-1:0] imem_req_addr_o;
   logic imem_rsp_valid_i;
   logic [INST_LEN-1:0] imem_rsp_data_i;
   logic id_valid_o;
   logic id_ready_i;
   logic [XLEN-1:0] id_pc_o;
   logic [INST_LEN-1:0] id_instr_o;
   logic [$clog2(DEPTH):0] inflight_o;
   modport master (
      input is_jump_i, pc_jump_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
      output imem_req_valid_o, imem_req_addr_o, id_valid_o, id_pc_o, id_instr_o, inflight_o
   );
   modport slave (
      output is_jump_i, pc_jump_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
      input imem_req_valid_o, imem_req_addr_o, id_valid_o, id_pc_o, id_instr_o, inflight_o
   );
endinterface

// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: fetch PC owner, in-order imem request tracking and ID-facing instruction buffer
module ifu_fetch_buf #(
   parameter int XLEN = 64,
   parameter int INST_LEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst_n,
   ifu_fetch_buf_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {RUN, DROP} state_t;
   state_t state, state_d;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0] inflight, drop_cnt, drop_d, rsp_dec;
   logic [CW-1:0] tag_wp, tag_rp, buf_wp, buf_rp, fifo_count;
   logic [CW:0] credit;
   logic [XLEN-1:0] tag_mem [DEPTH];
   logic [XLEN-1:0] pc_mem [DEPTH];
   logic [INST_LEN-1:0] ins_mem [DEPTH];
   logic fifo_empty, req_fire, rsp_take, id_pop;
   assign fifo_count = buf_wp - buf_rp;
   assign fifo_empty = buf_wp == buf_rp;
   assign credit = {1'b0, inflight} + {1'b0, fifo_count};
   assign rsp_dec = CW'(bus.imem_rsp_valid_i);
   // outstanding requests plus buffered entries never exceed DEPTH, so the buffer cannot overflow
   assign bus.imem_req_valid_o = rst_n && state == RUN && credit < (CW+1)'(DEPTH) && !bus.is_jump_i;
   assign bus.imem_req_addr_o = fetch_pc;
   assign bus.id_valid_o = !fifo_empty;
   assign bus.id_pc_o = fifo_empty ? '0 : pc_mem[buf_rp[AW-1:0]];
   assign bus.id_instr_o = fifo_empty ? '0 : ins_mem[buf_rp[AW-1:0]];
   assign bus.inflight_o = inflight;
   assign req_fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
   assign rsp_take = state == RUN && bus.imem_rsp_valid_i && !bus.is_jump_i;
   assign id_pop = !fifo_empty && bus.id_ready_i && !bus.is_jump_i;
   always_comb begin
      state_d = state;
      drop_d = drop_cnt;
      if (bus.is_jump_i) begin
         drop_d = inflight - rsp_dec;
         state_d = drop_d != '0 ? DROP : RUN;
      end else if (state == DROP && bus.imem_rsp_valid_i) begin
         drop_d = drop_cnt - CW'(1);
         state_d = drop_d == '0 ? RUN : DROP;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         tag_wp <= '0;
         tag_rp <= '0;
         buf_wp <= '0;
         buf_rp <= '0;
      end else begin
         state <= state_d;
         drop_cnt <= drop_d;
         inflight <= inflight + CW'(req_fire) - rsp_dec;
         if (bus.is_jump_i) begin
            fetch_pc <= {bus.pc_jump_i[XLEN-1:2], 2'b00};
            tag_rp <= tag_wp;
            buf_rp <= buf_wp;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (req_fire) tag_wp <= tag_wp + CW'(1);
            if (rsp_take) tag_rp <= tag_rp + CW'(1);
            if (rsp_take) buf_wp <= buf_wp + CW'(1);
            if (id_pop) buf_rp <= buf_rp + CW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (req_fire) tag_mem[tag_wp[AW-1:0]] <= fetch_pc;
      if (rsp_take) pc_mem[buf_wp[AW-1:0]] <= tag_mem[tag_rp[AW-1:0]];
      if (rsp_take) ins_mem[buf_wp[AW-1:0]] <= bus.imem_rsp_data_i;
   end
endmodule

// File: tb/tb_ifu_fetch_buf.sv
// tb_ifu_fetch_buf: directed per-cycle vectors against an in-order memory responder
module tb_ifu_fetch_buf;
   localparam int XLEN = 64;
   localparam int INST_LEN = 32;
   localparam int DEPTH = 2;
   localparam logic [63:0] A = 64'h8000_0000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [63:0] q[$];
   ifu_fetch_buf_if #(.XLEN(XLEN), .INST_LEN(INST_LEN), .DEPTH(DEPTH)) bus();
   ifu_fetch_buf #(.XLEN(XLEN), .INST_LEN(INST_LEN), .RESET_PC(A), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic rst, rr, ir, re, j;
      logic [63:0] pj;
      logic e_rv;
      logic [63:0] e_addr;
      logic e_idv;
      logic [63:0] e_pc;
      int e_inf;
   } vec_t;
   vec_t vec[$];
   function automatic vec_t mk(input logic rst, rr, ir, re, j, input logic [63:0] pj,
                               input logic e_rv, input logic [63:0] e_addr, input logic e_idv,
                               input logic [63:0] e_pc, input int e_inf);
      vec_t v;
      v.rst = rst; v.rr = rr; v.ir = ir; v.re = re; v.j = j; v.pj = pj;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_idv = e_idv; v.e_pc = e_pc; v.e_inf = e_inf;
      return v;
   endfunction
   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_req_ready_i = 1'b0;
      bus.id_ready_i = 1'b0;
      bus.is_jump_i = 1'b0;
      bus.pc_jump_i = '0;
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i = '0;
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst req_valid", 64'(bus.imem_req_valid_o), 64'd0);
      chk("rst req_addr", bus.imem_req_addr_o, A);
      chk("rst id_valid", 64'(bus.id_valid_o), 64'd0);
      chk("rst id_pc", bus.id_pc_o, 64'd0);
      chk("rst inflight", 64'(bus.inflight_o), 64'd0);
      rst_n = 1'b1;
   endtask
   task automatic run_row(input vec_t v, input int i);
      logic rsp_now, fire;
      logic [63:0] addr;
      if (v.rst) do_reset();
      bus.imem_req_ready_i = v.rr;
      bus.id_ready_i = v.ir;
      bus.is_jump_i = v.j;
      bus.pc_jump_i = v.pj;
      rsp_now = v.re && q.size() > 0;
      bus.imem_rsp_valid_i = rsp_now;
      bus.imem_rsp_data_i = '0;
      if (rsp_now) bus.imem_rsp_data_i = inst_of(q[0]);
      @(negedge clk);
      chk($sformatf("row%0d req_valid", i), 64'(bus.imem_req_valid_o), 64'(v.e_rv));
      chk($sformatf("row%0d req_addr", i), bus.imem_req_addr_o, v.e_addr);
      chk($sformatf("row%0d id_valid", i), 64'(bus.id_valid_o), 64'(v.e_idv));
      chk($sformatf("row%0d inflight", i), 64'(bus.inflight_o), 64'(v.e_inf));
      if (v.e_idv) begin
         chk($sformatf("row%0d id_pc", i), bus.id_pc_o, v.e_pc);
         chk($sformatf("row%0d id_instr", i), 64'(bus.id_instr_o), 64'(inst_of(v.e_pc)));
      end
      fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
      addr = bus.imem_req_addr_o;
      @(posedge clk);
      #1;
      if (rsp_now) void'(q.pop_front());
      if (fire) q.push_back(addr);
   endtask
   initial begin
      // streaming with memory and ID always ready
      vec.push_back(mk(1,1,1,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+4,   0,0,   1));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+8,   1,A,   1));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+8,   1,A+4, 0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+12,  0,0,   1));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+16,  1,A+8, 1));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+16,  1,A+12,0));
      // ID stalled: buffer fills, head holds, issue resumes at +8
      vec.push_back(mk(1,1,0,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,1,0,1,0,0, 1,A+4,   0,0,   1));
      vec.push_back(mk(0,1,0,1,0,0, 0,A+8,   1,A,   1));
      vec.push_back(mk(0,1,0,1,0,0, 0,A+8,   1,A,   0));
      vec.push_back(mk(0,1,0,1,0,0, 0,A+8,   1,A,   0));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+8,   1,A,   0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+8,   1,A+4, 0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+12,  0,0,   1));
      // memory not ready for three cycles
      vec.push_back(mk(1,0,1,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,0,1,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,0,1,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+4,   0,0,   1));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+8,   1,A,   1));
      // redirect with two in flight: both late responses dropped
      vec.push_back(mk(1,1,0,0,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,1,0,0,0,0, 1,A+4,   0,0,   1));
      vec.push_back(mk(0,1,0,0,0,0, 0,A+8,   0,0,   2));
      vec.push_back(mk(0,1,0,0,1,A+'h102, 0,A+8, 0,0, 2));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+'h100,0,0,  2));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+'h100,0,0,  1));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+'h100,0,0,  0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+'h104,0,0,  1));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+'h108,1,A+'h100,1));
      // redirect coinciding with the only in-flight response, one entry buffered
      vec.push_back(mk(1,1,0,1,0,0, 1,A,     0,0,   0));
      vec.push_back(mk(0,1,0,1,0,0, 1,A+4,   0,0,   1));
      vec.push_back(mk(0,1,0,1,1,A+'h207, 0,A+8, 1,A, 1));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+'h204,0,0,  0));
      vec.push_back(mk(0,1,1,1,0,0, 1,A+'h208,0,0,  1));
      vec.push_back(mk(0,1,1,1,0,0, 0,A+'h20c,1,A+'h204,1));
      // fetch PC wraps past the top of the address space
      vec.push_back(mk(1,1,1,1,1,64'hFFFF_FFFF_FFFF_FFFE, 0,A, 0,0, 0));
      vec.push_back(mk(0,1,1,1,0,0, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,0, 0));
      vec.push_back(mk(0,1,1,1,0,0, 1,64'd0, 0,0, 1));
      vec.push_back(mk(0,1,1,1,0,0, 0,64'd4, 1,64'hFFFF_FFFF_FFFF_FFFC, 1));
      foreach (vec[i]) run_row(vec[i], i);
      // fill the buffer, then pull reset low between clock edges
      run_row(mk(1,1,0,1,0,0, 1,A,   0,0, 0), 100);
      run_row(mk(0,1,0,1,0,0, 1,A+4, 0,0, 1), 101);
      run_row(mk(0,1,0,1,0,0, 0,A+8, 1,A, 1), 102);
      run_row(mk(0,1,0,1,0,0, 0,A+8, 1,A, 0), 103);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst id_valid", 64'(bus.id_valid_o), 64'd0);
      chk("midrst req_addr", bus.imem_req_addr_o, A);
      chk("midrst inflight", 64'(bus.inflight_o), 64'd0);
      chk("midrst req_valid", 64'(bus.imem_req_valid_o), 64'd0);
      chk("midrst id_pc", bus.id_pc_o, 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
